clken_sequencer: RTL

//  Multi-channel clock-enable scheduler built around the team's decimating clken counter scheme.

---
 rtl/clken_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/clken_sequencer.sv
// Multi-channel clock-enable sequencer. Each channel divides the system
// clock by its own decimation ratio and starts from its own phase. A start
// command launches all channels together and a stop command halts them
// together.
module clken_sequencer #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 20,
  parameter logic [CNT_W-1:0] DEFAULT_DECIMATION = CNT_W'(16)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_decimation,
  input  logic [CNT_W-1:0]  cfg_phase,
  output logic              cfg_err,
  input  logic              start,
  input  logic              stop,
  output logic              running,
  output logic              sync_pulse,
  output logic [NUM_CH-1:0] clken
);

  localparam int unsigned CH_W = 3;
  localparam logic [CH_W:0] NUM_CH_V = (CH_W+1)'(NUM_CH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] dec_q   [NUM_CH];
  logic [CNT_W-1:0] phase_q [NUM_CH];
  logic [CNT_W-1:0] cnt_q   [NUM_CH];

  logic             cfg_fire;
  logic             cfg_ch_ok;
  logic [CNT_W-1:0] cfg_phase_clamped;

  // Config is only accepted while idle, so a live schedule never changes.
  assign cfg_ready = (state == S_IDLE);
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign cfg_ch_ok = ({1'b0, cfg_ch} < NUM_CH_V);

  // Start phase must lie inside the decimation period; a disabled channel keeps phase 0.
  always_comb begin
    cfg_phase_clamped = cfg_phase;
    if (cfg_decimation == '0) begin
      cfg_phase_clamped = '0;
    end else if (cfg_phase >= cfg_decimation) begin
      cfg_phase_clamped = cfg_decimation - CNT_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: stop wins over start, ARM lasts a single cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && !stop) state_nxt = S_ARM;
      S_ARM:   state_nxt = stop ? S_IDLE : S_RUN;
      S_RUN:   if (stop) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Per-channel decimation/phase registers and the bad-channel error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        dec_q[i]   <= DEFAULT_DECIMATION;
        phase_q[i] <= '0;
      end
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_fire && !cfg_ch_ok;
      if (cfg_fire && cfg_ch_ok) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (cfg_ch == CH_W'(i)) begin
            dec_q[i]   <= cfg_decimation;
            phase_q[i] <= cfg_phase_clamped;
          end
        end
      end
    end
  end

  // Phase-aligned counters; a wrap produces the channel's clken one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
      clken <= '0;
    end else begin
      clken <= '0;
      case (state)
        S_ARM: begin
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= stop ? '0 : phase_q[i];
          end
        end
        S_RUN: begin
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (stop || dec_q[i] == '0) begin
              cnt_q[i] <= '0;
            end else if (cnt_q[i] == dec_q[i] - CNT_W'(1)) begin
              cnt_q[i] <= '0;
              clken[i] <= 1'b1;
            end else begin
              cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
          end
        end
        default: begin
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= '0;
          end
        end
      endcase
    end
  end

  // Status outputs: running mirrors RUN, sync marks the first RUN cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      running    <= 1'b0;
      sync_pulse <= 1'b0;
    end else begin
      running    <= (state_nxt == S_RUN);
      sync_pulse <= (state == S_ARM) && (state_nxt == S_RUN);
    end
  end

endmodule
